// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module     : mem_ctrl_pkg
//  Description: Shared definitions for the byte-serial memory controller:
//               load/store width codes (funct3), controller state encoding,
//               default IO region base and a transfer-size helper.
//  Revision   : 1.0  initial release
// ============================================================================
package mem_ctrl_pkg;

  // Lowest address of the memory-mapped IO region.
  localparam logic [31:0] c_io_base_default = 32'h0003_0000;

  // funct3 width/sign codes carried on lsb_precise.
  localparam logic [2:0] c_f3_b  = 3'b000;
  localparam logic [2:0] c_f3_h  = 3'b001;
  localparam logic [2:0] c_f3_w  = 3'b010;
  localparam logic [2:0] c_f3_bu = 3'b100;
  localparam logic [2:0] c_f3_hu = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_STORE = 3'd2,
    ST_FETCH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Number of bytes moved for a funct3 code. The reserved width code 2'b11
  // is treated as a word so the 3-bit byte counter can never overflow.
  function automatic logic [2:0] size_of(input logic [2:0] f3);
    logic [2:0] n;
    case (f3[1:0])
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ld_ext.sv
`default_nettype none
// ============================================================================
//  Module     : mem_ld_ext
//  Description: Combinational load-data extender. Sign- or zero-extends the
//               low byte/halfword of the assembled raw word according to the
//               funct3 width code; words pass through unchanged.
//  Ports      : i_precise  funct3 width/sign code
//               i_raw      little-endian assembled bytes
//               o_ext      extended 32-bit load result
//  Revision   : 1.0  initial release
// ============================================================================
module mem_ld_ext
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  i_precise,
  input  logic [31:0] i_raw,
  output logic [31:0] o_ext
);

  always_comb begin
    o_ext = i_raw;
    case (i_precise)
      c_f3_b:  o_ext = {{24{i_raw[7]}},  i_raw[7:0]};
      c_f3_h:  o_ext = {{16{i_raw[15]}}, i_raw[15:0]};
      c_f3_bu: o_ext = {24'h00_0000,     i_raw[7:0]};
      c_f3_hu: o_ext = {16'h0000,        i_raw[15:0]};
      default: o_ext = i_raw;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : mem_ctrl
//  Description: Single-port byte-serial memory controller. Arbitrates the
//               load/store buffer (priority) and instruction fetch onto an
//               8-bit RAM bus, one transaction at a time, and returns
//               extended load data / instruction words with a done pulse.
//  Ports      : clk, rst            clock, synchronous active-high reset
//               rdy                 global enable (freeze when low)
//               rollback            speculative flush (loads/fetches only)
//               lsb_*               load/store request and completion
//               if_*                fetch request and completion
//               mem_din/dout/a/wr   8-bit RAM bus (read data 1 cycle late)
//               io_buffer_full      back-pressure for IO-region stores
//  Revision   : 1.0  initial release
// ============================================================================
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE = c_io_base_default
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        lsb_req,
  input  logic        lsb_ls,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_data,
  input  logic [2:0]  lsb_precise,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_t      state_q,     state_d;
  logic [2:0]  cnt_q,       cnt_d;
  logic [2:0]  size_q,      size_d;
  logic [2:0]  precise_q,   precise_d;
  logic [31:0] addr_q,      addr_d;
  logic [31:0] data_q,      data_d;
  logic [31:0] raw_q,       raw_d;
  logic        lsb_done_q,  lsb_done_d;
  logic [31:0] lsb_rdata_q, lsb_rdata_d;
  logic        if_done_q,   if_done_d;
  logic [31:0] if_inst_q,   if_inst_d;
  logic        mem_wr_q,    mem_wr_d;
  logic [31:0] mem_a_q,     mem_a_d;
  logic [7:0]  mem_dout_q,  mem_dout_d;

  logic [1:0]  w_cap_idx;
  logic [31:0] w_raw_cap;
  logic [31:0] w_ld_ext;
  logic [31:0] w_st_addr;

  // Read data trails the address by one cycle, so while the counter reads i
  // the byte on mem_din belongs to address addr+i-1.
  always_comb begin
    w_cap_idx = cnt_q[1:0] - 2'd1;
    w_raw_cap = raw_q;
    w_raw_cap[{w_cap_idx, 3'b000} +: 8] = mem_din;
  end

  assign w_st_addr = addr_q + 32'(cnt_q);

  mem_ld_ext u_ld_ext (
    .i_precise (precise_q),
    .i_raw     (w_raw_cap),
    .o_ext     (w_ld_ext)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    precise_d   = precise_q;
    addr_d      = addr_q;
    data_d      = data_q;
    raw_d       = raw_q;
    lsb_done_d  = lsb_done_q;
    lsb_rdata_d = lsb_rdata_q;
    if_done_d   = if_done_q;
    if_inst_d   = if_inst_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    // A write strobe is only ever asserted for the one cycle it is issued.
    mem_wr_d    = 1'b0;

    if (rdy) begin
      lsb_done_d = 1'b0;
      if_done_d  = 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (!rollback) begin
            if (lsb_req) begin
              addr_d    = lsb_addr;
              data_d    = lsb_data;
              precise_d = lsb_precise;
              size_d    = size_of(lsb_precise);
              raw_d     = '0;
              cnt_d     = 3'd0;
              mem_a_d   = lsb_addr;
              if (lsb_ls) begin
                state_d = ST_LOAD;
              end else begin
                state_d    = ST_STORE;
                mem_dout_d = lsb_data[7:0];
                // The first byte goes out straight from IDLE unless the IO
                // sink is full; otherwise STORE retries it from count 0.
                if (!(io_buffer_full && (lsb_addr >= IO_BASE))) begin
                  mem_wr_d = 1'b1;
                  cnt_d    = 3'd1;
                end
              end
            end else if (if_req) begin
              state_d   = ST_FETCH;
              addr_d    = if_addr;
              precise_d = c_f3_w;
              size_d    = 3'd4;
              raw_d     = '0;
              cnt_d     = 3'd0;
              mem_a_d   = if_addr;
            end
          end
        end

        ST_LOAD, ST_FETCH: begin
          if (rollback) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
          end else begin
            if (cnt_q != 3'd0) begin
              raw_d = w_raw_cap;
            end
            if (cnt_q == size_q) begin
              // Last byte is on mem_din now; finish with the assembled word.
              state_d = ST_DONE;
              cnt_d   = 3'd0;
              if (state_q == ST_LOAD) begin
                lsb_done_d  = 1'b1;
                lsb_rdata_d = w_ld_ext;
              end else begin
                if_done_d = 1'b1;
                if_inst_d = w_raw_cap;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
              if ((cnt_q + 3'd1) != size_q) begin
                mem_a_d = addr_q + 32'(cnt_q) + 32'd1;
              end
            end
          end
        end

        ST_STORE: begin
          // Committed stores ignore rollback.
          if (cnt_q == size_q) begin
            state_d    = ST_DONE;
            cnt_d      = 3'd0;
            lsb_done_d = 1'b1;
          end else begin
            mem_a_d    = w_st_addr;
            mem_dout_d = data_q[{cnt_q[1:0], 3'b000} +: 8];
            if (!(io_buffer_full && (w_st_addr >= IO_BASE))) begin
              mem_wr_d = 1'b1;
              cnt_d    = cnt_q + 3'd1;
            end
          end
        end

        ST_DONE: begin
          // Requester is still holding req this cycle; do not re-accept it.
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      size_q      <= 3'd0;
      precise_q   <= 3'd0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      raw_q       <= 32'd0;
      lsb_done_q  <= 1'b0;
      lsb_rdata_q <= 32'd0;
      if_done_q   <= 1'b0;
      if_inst_q   <= 32'd0;
      mem_wr_q    <= 1'b0;
      mem_a_q     <= 32'd0;
      mem_dout_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      precise_q   <= precise_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      raw_q       <= raw_d;
      lsb_done_q  <= lsb_done_d;
      lsb_rdata_q <= lsb_rdata_d;
      if_done_q   <= if_done_d;
      if_inst_q   <= if_inst_d;
      mem_wr_q    <= mem_wr_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
    end
  end

  assign lsb_done  = lsb_done_q;
  assign lsb_rdata = lsb_rdata_q;
  assign if_done   = if_done_q;
  assign if_inst   = if_inst_q;
  assign mem_wr    = mem_wr_q;
  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;

endmodule
`default_nettype wire
